// File: rtl/div_recon_seq_if.sv
// rtl/div_recon_seq_if.sv - operand/result handshake bundle for div_recon_seq
//
// Purpose: groups the request channel (in_valid/in_ready plus the tc,
// quotient, divisor and remainder operands) and the result channel
// (out_valid/out_ready plus dividend, ovf and consistent) into one bundle.
//   master : the requester / result consumer (drives operands and out_ready)
//   slave  : the reconstruction block (drives in_ready and the results)
// Parameter width must match the width of the div_recon_seq instance.

interface div_recon_seq_if #(
    parameter int width = 8
);
    logic             in_valid;
    logic             in_ready;
    logic             tc;
    logic [width-1:0] quotient;
    logic [width-1:0] divisor;
    logic [width-1:0] remainder;
    logic             out_valid;
    logic             out_ready;
    logic [width-1:0] dividend;
    logic             ovf;
    logic             consistent;

    modport master (
        output in_valid, tc, quotient, divisor, remainder, out_ready,
        input  in_ready, out_valid, dividend, ovf, consistent
    );

    modport slave (
        input  in_valid, tc, quotient, divisor, remainder, out_ready,
        output in_ready, out_valid, dividend, ovf, consistent
    );
endinterface

// File: rtl/div_recon_seq.sv
// rtl/div_recon_seq.sv - sequential dividend reconstruction (q*b + r)
//
// Purpose: rebuilds dividend = quotient*divisor + remainder, one quotient bit
// per cycle, for unsigned (tc=0) or two's-complement (tc=1) operands, and
// flags when the exact result does not fit in width bits.
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset, returns to IDLE and drops any op
//   bus  - div_recon_seq_if.slave: in_valid/in_ready + tc/quotient/divisor/
//          remainder in; out_valid/out_ready + dividend/ovf/consistent out
// Configuration macro: DIV_RECON_CHECK_EN compiles in the operand legality
// checker driving consistent; without it consistent is tied to 0.
// Timing: accept edge, width CALC cycles, one FIN cycle, then DONE holds the
// result until out_ready; a new operand set is taken one cycle after that.

module div_recon_seq #(
    parameter int width = 8
) (
    input logic            clk,
    input logic            rst,
    div_recon_seq_if.slave bus
);

    localparam int AW = 2 * width + 1;
    localparam int CW = $clog2(width + 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIN,
        DONE
    } state_t;

    state_t           state_q;
    logic [width-1:0] qsh_q;      // |quotient|, shifted left one bit per CALC cycle
    logic             neg_q;      // product sign: sign(q) xor sign(b) in tc mode
    logic [width-1:0] b_q;
    logic [width-1:0] r_q;
    logic             tc_q;
    logic [AW-1:0]    acc_q;      // |q|*|b| built MSB-first
    logic [CW-1:0]    cnt_q;
    logic             in_ready_q;
    logic             out_valid_q;
    logic [width-1:0] dividend_q;
    logic             ovf_q;

    // Operand magnitudes. -x of the most negative value wraps to 2^(width-1),
    // which is still the correct unsigned magnitude in width bits.
    logic             in_q_neg;
    logic             in_b_neg;
    logic [width-1:0] in_q_mag;
    logic             b_neg;
    logic [width-1:0] b_mag;

    assign in_q_neg = bus.tc & bus.quotient[width-1];
    assign in_b_neg = bus.tc & bus.divisor[width-1];
    assign in_q_mag = in_q_neg ? -bus.quotient : bus.quotient;
    assign b_neg    = tc_q & b_q[width-1];
    assign b_mag    = b_neg ? -b_q : b_q;

    // Shift-add step: acc = 2*acc + (next quotient bit ? |b| : 0).
    logic [AW-1:0] addend;
    logic [AW-1:0] acc_d;

    assign addend = {{(AW - width){1'b0}}, b_mag} & {AW{qsh_q[width-1]}};
    assign acc_d  = {acc_q[AW-2:0], 1'b0} + addend;

    // Final value. |q|*|b| < 2^(2*width), so the top accumulator bit is free
    // to act as the sign after negation, and adding a sign-extended remainder
    // cannot overflow AW bits: full_d is the exact result.
    logic [AW-1:0] prod;
    logic [AW-1:0] r_ext;
    logic [AW-1:0] full_d;
    logic          ovf_d;

    assign prod   = neg_q ? -acc_q : acc_q;
    assign r_ext  = {{(AW - width){tc_q & r_q[width-1]}}, r_q};
    assign full_d = prod + r_ext;

    // Signed fit: bits [AW-1:width-1] must all equal the sign.
    // Unsigned fit: nothing may be set at or above bit width.
    assign ovf_d = tc_q ? ~((&full_d[AW-1:width-1]) | ~(|full_d[AW-1:width-1]))
                        : (|full_d[AW-1:width]);

`ifdef DIV_RECON_CHECK_EN
    logic             r_neg;
    logic [width-1:0] r_mag;
    logic             cons_d;
    logic             consistent_q;

    assign r_neg  = tc_q & r_q[width-1];
    assign r_mag  = r_neg ? -r_q : r_q;
    // A real division leaves a remainder smaller than the divisor and, in
    // two's complement, carrying the dividend's sign (or zero).
    assign cons_d = (|b_q) & (r_mag < b_mag) &
                    (~tc_q | ~(|r_q) | (r_q[width-1] == full_d[AW-1]));
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            qsh_q        <= '0;
            neg_q        <= 1'b0;
            b_q          <= '0;
            r_q          <= '0;
            tc_q         <= 1'b0;
            acc_q        <= '0;
            cnt_q        <= '0;
            in_ready_q   <= 1'b1;
            out_valid_q  <= 1'b0;
            dividend_q   <= '0;
            ovf_q        <= 1'b0;
`ifdef DIV_RECON_CHECK_EN
            consistent_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid && in_ready_q) begin
                        qsh_q      <= in_q_mag;
                        neg_q      <= in_q_neg ^ in_b_neg;
                        b_q        <= bus.divisor;
                        r_q        <= bus.remainder;
                        tc_q       <= bus.tc;
                        acc_q      <= '0;
                        cnt_q      <= '0;
                        in_ready_q <= 1'b0;
                        state_q    <= CALC;
                    end
                end
                CALC: begin
                    acc_q <= acc_d;
                    qsh_q <= {qsh_q[width-2:0], 1'b0};
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q == CW'(width - 1)) begin
                        state_q <= FIN;
                    end
                end
                FIN: begin
                    dividend_q   <= full_d[width-1:0];
                    ovf_q        <= ovf_d;
`ifdef DIV_RECON_CHECK_EN
                    consistent_q <= cons_d;
`endif
                    out_valid_q  <= 1'b1;
                    state_q      <= DONE;
                end
                DONE: begin
                    // in_ready stays low here, so a request on the handshake
                    // edge waits until IDLE is visible.
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    in_ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.dividend  = dividend_q;
    assign bus.ovf       = ovf_q;
`ifdef DIV_RECON_CHECK_EN
    assign bus.consistent = consistent_q;
`else
    assign bus.consistent = 1'b0;
`endif

endmodule

// File: tb/tb_div_recon_seq.sv
// tb/tb_div_recon_seq.sv - self-checking bench for div_recon_seq

module tb_div_recon_seq;
    localparam int W = 8;
`ifdef DIV_RECON_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    div_recon_seq_if #(.width(W)) bus ();
    div_recon_seq #(.width(W)) dut (.clk(clk), .rst(rst), .bus(bus));

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic         tc;
        logic [W-1:0] q;
        logic [W-1:0] b;
        logic [W-1:0] r;
        logic [W-1:0] d;
        logic         o;
        logic         c;   // expected consistent when the checker is built in
    } vec_t;

    vec_t vecs[13];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic longint sval(input logic t, input logic [W-1:0] x);
        longint v;
        v = longint'(x);
        if (t && x[W-1]) v = v - (longint'(1) << W);
        return v;
    endfunction

    function automatic longint labs(input longint v);
        return (v < 0) ? -v : v;
    endfunction

    // Reference: exact arithmetic on integers, then the range/legality rules.
    function automatic void model(input logic t, input logic [W-1:0] q, b, r,
                                  output logic [W-1:0] d, output logic o, output logic c);
        longint qs, bs, rs, full;
        qs = sval(t, q);
        bs = sval(t, b);
        rs = sval(t, r);
        full = qs * bs + rs;
        d = full[W-1:0];
        if (t) o = (full < -(longint'(1) << (W - 1))) || (full > (longint'(1) << (W - 1)) - 1);
        else   o = (full >= (longint'(1) << W));
        c = CHK && (bs != 0) && (labs(rs) < labs(bs)) &&
            (!t || rs == 0 || ((rs < 0) == (full < 0)));
    endfunction

    task automatic run_op(input logic t, input logic [W-1:0] q, b, r,
                          output logic [W-1:0] d, output logic o, output logic c,
                          output int lat);
        int k;
        @(negedge clk);
        bus.tc = t; bus.quotient = q; bus.divisor = b; bus.remainder = r;
        bus.in_valid = 1'b1;
        k = 0;
        while (bus.in_ready !== 1'b1 && k < 40) begin
            @(negedge clk);
            k++;
        end
        @(posedge clk);
        #1;
        // Scramble inputs after the accepting edge; the op in flight must not care.
        bus.in_valid  = 1'b0;
        bus.tc        = 1'($urandom);
        bus.quotient  = W'($urandom);
        bus.divisor   = W'($urandom);
        bus.remainder = W'($urandom);
        lat = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (bus.out_valid === 1'b1) begin
                lat = i;
                break;
            end
        end
        d = bus.dividend;
        o = bus.ovf;
        c = bus.consistent;
        @(posedge clk);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        logic [W-1:0] d, ed, tq, tb, tr;
        logic o, c, eo, ec, tt, seen;
        int lat, first, second, k;

        vecs[0]  = '{1'b0, 8'd25,  8'd10,  8'd3,   8'd253, 1'b0, 1'b1};
        vecs[1]  = '{1'b0, 8'd26,  8'd10,  8'd0,   8'd4,   1'b1, 1'b1};
        vecs[2]  = '{1'b1, 8'hF4,  8'h0A,  8'hF8,  8'h80,  1'b0, 1'b1};
        vecs[3]  = '{1'b1, 8'h80,  8'hFF,  8'h00,  8'h80,  1'b1, 1'b1};
        vecs[4]  = '{1'b0, 8'd7,   8'd0,   8'd9,   8'd9,   1'b0, 1'b0};
        vecs[5]  = '{1'b1, 8'h85,  8'h00,  8'hF0,  8'hF0,  1'b0, 1'b0};
        vecs[6]  = '{1'b0, 8'hFF,  8'hFF,  8'hFF,  8'h00,  1'b1, 1'b0};
        vecs[7]  = '{1'b1, 8'h7F,  8'h7F,  8'h00,  8'h01,  1'b1, 1'b1};
        vecs[8]  = '{1'b1, 8'hFF,  8'hFF,  8'h7F,  8'h80,  1'b1, 1'b0};
        vecs[9]  = '{1'b1, 8'h80,  8'h01,  8'h00,  8'h80,  1'b0, 1'b1};
        vecs[10] = '{1'b0, 8'h00,  8'h00,  8'h00,  8'h00,  1'b0, 1'b0};
        vecs[11] = '{1'b1, 8'hFF,  8'h05,  8'hFD,  8'hF8,  1'b0, 1'b1};
        vecs[12] = '{1'b1, 8'h02,  8'h05,  8'hFD,  8'h07,  1'b0, 1'b0};

        rst = 1'b1;
        bus.in_valid = 1'b0; bus.out_ready = 1'b1; bus.tc = 1'b0;
        bus.quotient = '0; bus.divisor = '0; bus.remainder = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_in_ready", bus.in_ready, 1);
        check("reset_out_valid", bus.out_valid, 0);
        check("reset_dividend", bus.dividend, 0);
        check("reset_ovf", bus.ovf, 0);
        check("reset_consistent", bus.consistent, 0);
        rst = 1'b0;

        for (int i = 0; i < 13; i++) begin
            run_op(vecs[i].tc, vecs[i].q, vecs[i].b, vecs[i].r, d, o, c, lat);
            check($sformatf("vec%0d_dividend", i), d, vecs[i].d);
            check($sformatf("vec%0d_ovf", i), o, vecs[i].o);
            check($sformatf("vec%0d_consistent", i), c, CHK ? vecs[i].c : 1'b0);
            check($sformatf("vec%0d_latency", i), lat, W + 2);
        end

        for (int i = 0; i < 250; i++) begin
            tt = 1'($urandom);
            tq = W'($urandom);
            tb = ($urandom_range(0, 15) == 0) ? '0 : W'($urandom);
            tr = W'($urandom);
            if ($urandom_range(0, 3) == 0) tr = W'($urandom_range(0, 3));
            model(tt, tq, tb, tr, ed, eo, ec);
            run_op(tt, tq, tb, tr, d, o, c, lat);
            check($sformatf("rnd%0d_dividend tc=%0d q=%0h b=%0h r=%0h", i, tt, tq, tb, tr), d, ed);
            check($sformatf("rnd%0d_ovf", i), o, eo);
            check($sformatf("rnd%0d_consistent", i), c, ec);
            check($sformatf("rnd%0d_latency", i), lat, W + 2);
        end

        // Back-to-back throughput with out_ready held high.
        @(negedge clk);
        bus.tc = 1'b0; bus.quotient = 8'd3; bus.divisor = 8'd4; bus.remainder = 8'd1;
        bus.in_valid = 1'b1;
        first = -1; second = -1;
        for (int i = 0; i < 60 && second < 0; i++) begin
            @(negedge clk);
            if (bus.in_ready === 1'b1) begin
                if (first < 0) first = i;
                else second = i;
            end
        end
        check("throughput_cycles", second - first, W + 3);
        bus.in_valid = 1'b0;
        k = 0;
        while (bus.in_ready !== 1'b1 && k < 40) begin
            @(negedge clk);
            k++;
        end

        // Result held in DONE with out_ready low and a new request pending.
        bus.out_ready = 1'b0;
        bus.tc = 1'b0; bus.quotient = 8'd25; bus.divisor = 8'd10; bus.remainder = 8'd3;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.quotient = 8'd2; bus.divisor = 8'd3; bus.remainder = 8'd1;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.out_valid === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        check("hold_valid_seen", seen, 1);
        repeat (5) begin
            @(negedge clk);
            check("hold_out_valid", bus.out_valid, 1);
            check("hold_dividend", bus.dividend, 253);
            check("hold_ovf", bus.ovf, 0);
            check("hold_in_ready", bus.in_ready, 0);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("post_hs_out_valid", bus.out_valid, 0);
        check("post_hs_in_ready", bus.in_ready, 1);
        @(negedge clk);
        check("new_set_accepted", bus.in_ready, 0);
        bus.in_valid = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.out_valid === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        check("new_set_valid_seen", seen, 1);
        check("new_set_dividend", bus.dividend, 7);
        @(posedge clk);

        // Reset on the 4th CALC cycle discards the op.
        @(negedge clk);
        bus.tc = 1'b0; bus.quotient = 8'hFF; bus.divisor = 8'hFF; bus.remainder = 8'd5;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_in_ready", bus.in_ready, 1);
        check("midrst_out_valid", bus.out_valid, 0);
        check("midrst_dividend", bus.dividend, 0);
        check("midrst_ovf", bus.ovf, 0);
        check("midrst_consistent", bus.consistent, 0);
        rst = 1'b0;
        seen = 1'b0;
        repeat (15) begin
            @(negedge clk);
            if (bus.out_valid !== 1'b0) seen = 1'b1;
        end
        check("midrst_no_result", seen, 0);
        run_op(1'b0, 8'd5, 8'd3, 8'd4, d, o, c, lat);
        check("postrst_dividend", d, 19);
        check("postrst_ovf", o, 0);
        check("postrst_consistent", c, 0);
        check("postrst_latency", lat, W + 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
